// File: rtl/jedro_1_alu_core.sv
// jedro_1_alu_core: single-cycle RV32I integer ALU with registered result,
// signed-overflow flag and writeback address/enable for regfile port C.
// Optional feature macro: JEDRO_1_ALU_ZERO_FLAG_EN (adds registered zero_o).
module jedro_1_alu_core #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ALU_OP_WIDTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op_sel_i,
    input  logic [DATA_WIDTH-1:0]     opa_i,
    input  logic [DATA_WIDTH-1:0]     opb_i,
    output logic [DATA_WIDTH-1:0]     res_o,
    output logic                      overflow_o,
`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
    output logic                      zero_o,
`endif
    input  logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_i,
    output logic [REG_ADDR_WIDTH-1:0] reg_alu_dest_addr_o,
    input  logic                      alu_reg_wb_i,
    output logic                      alu_reg_wb_o
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam int unsigned MSB     = DATA_WIDTH - 1;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(4'b0000);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(4'b1000);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(4'b0001);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(4'b0010);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(4'b0011);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4'b0100);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(4'b0101);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(4'b1101);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(4'b0110);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(4'b0111);

    logic [DATA_WIDTH-1:0]     res_d, res_q;
    logic                      overflow_d, overflow_q;
    logic [REG_ADDR_WIDTH-1:0] dest_d, dest_q;
    logic                      wb_d, wb_q;
    logic                      legal_c;
    logic [SHAMT_W-1:0]        shamt_c;
    logic [DATA_WIDTH-1:0]     sum_c, diff_c;
    logic                      slt_c, sltu_c;

    assign shamt_c = opb_i[SHAMT_W-1:0];
    assign sum_c   = opa_i + opb_i;
    assign diff_c  = opa_i - opb_i;
    assign slt_c   = $signed(opa_i) < $signed(opb_i);
    assign sltu_c  = opa_i < opb_i;

    // Result, overflow and writeback-enable for the op presented this cycle
    always_comb begin
        res_d      = '0;
        overflow_d = 1'b0;
        legal_c    = 1'b1;
        case (alu_op_sel_i)
            OP_ADD: begin
                res_d      = sum_c;
                overflow_d = (opa_i[MSB] == opb_i[MSB]) && (sum_c[MSB] != opa_i[MSB]);
            end
            OP_SUB: begin
                res_d      = diff_c;
                overflow_d = (opa_i[MSB] != opb_i[MSB]) && (diff_c[MSB] != opa_i[MSB]);
            end
            OP_SLL:  res_d = opa_i << shamt_c;
            OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, slt_c};
            OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, sltu_c};
            OP_XOR:  res_d = opa_i ^ opb_i;
            OP_SRL:  res_d = opa_i >> shamt_c;
            OP_SRA:  res_d = $unsigned($signed(opa_i) >>> shamt_c);
            OP_OR:   res_d = opa_i | opb_i;
            OP_AND:  res_d = opa_i & opb_i;
            default: legal_c = 1'b0;
        endcase
        dest_d = reg_alu_dest_addr_i;
        // x0 is never written; illegal ops never write
        wb_d   = alu_reg_wb_i && legal_c && (reg_alu_dest_addr_i != '0);
    end

    // Output pipeline register with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            res_q      <= '0;
            overflow_q <= 1'b0;
            dest_q     <= '0;
            wb_q       <= 1'b0;
        end else begin
            res_q      <= res_d;
            overflow_q <= overflow_d;
            dest_q     <= dest_d;
            wb_q       <= wb_d;
        end
    end

    assign res_o               = res_q;
    assign overflow_o          = overflow_q;
    assign reg_alu_dest_addr_o = dest_q;
    assign alu_reg_wb_o        = wb_q;

`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
    logic zero_d, zero_q;

    assign zero_d = (res_d == '0);

    // Zero flag registered alongside the result
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;
`endif

endmodule

// File: tb/tb_jedro_1_alu_core.sv
// Testbench for jedro_1_alu_core: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_jedro_1_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        ovf;
    logic [4:0]  dest_i, dest_o;
    logic        wb_i, wb_o;
`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
    logic        zero;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jedro_1_alu_core dut (
        .clk_i               (clk),
        .rstn_i              (rst),
        .alu_op_sel_i        (op),
        .opa_i               (a),
        .opb_i               (b),
        .res_o               (res),
        .overflow_o          (ovf),
`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
        .zero_o              (zero),
`endif
        .reg_alu_dest_addr_i (dest_i),
        .reg_alu_dest_addr_o (dest_o),
        .alu_reg_wb_i        (wb_i),
        .alu_reg_wb_o        (wb_o)
    );

    // Reference: arithmetic on wide signed integers, overflow = lost precision
    function automatic void model(input logic [3:0] m_op, input logic [31:0] m_a,
                                  input logic [31:0] m_b, output logic [31:0] m_r,
                                  output logic m_ovf, output logic m_legal);
        longint sa, sb, exact;
        int unsigned sh;
        sa      = longint'($signed(m_a));
        sb      = longint'($signed(m_b));
        sh      = int'(m_b % 32);
        m_r     = 32'h0;
        m_ovf   = 1'b0;
        m_legal = 1'b1;
        case (m_op)
            4'h0: begin exact = sa + sb; m_r = 32'(exact); m_ovf = exact != longint'($signed(m_r)); end
            4'h8: begin exact = sa - sb; m_r = 32'(exact); m_ovf = exact != longint'($signed(m_r)); end
            4'h1: m_r = 32'(longint'(m_a) * (64'd1 << sh));
            4'h2: m_r = (sa < sb) ? 32'd1 : 32'd0;
            4'h3: m_r = (m_a < m_b) ? 32'd1 : 32'd0;
            4'h4: m_r = m_a ^ m_b;
            4'h5: m_r = 32'(longint'(m_a) / (64'd1 << sh));
            4'hD: m_r = 32'(sa >>> sh);
            4'h6: m_r = m_a | m_b;
            4'h7: m_r = m_a & m_b;
            default: m_legal = 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one op, clock it, then check every output against the model
    task automatic step(input string tag, input logic [3:0] s_op, input logic [31:0] s_a,
                        input logic [31:0] s_b, input logic [4:0] s_d, input logic s_wb);
        logic [31:0] er;
        logic        eo, el;
        model(s_op, s_a, s_b, er, eo, el);
        op = s_op; a = s_a; b = s_b; dest_i = s_d; wb_i = s_wb;
        @(posedge clk); #1;
        chk({tag, ".res"},  res, er);
        chk({tag, ".ovf"},  32'(ovf), 32'(eo));
        chk({tag, ".dest"}, 32'(dest_o), 32'(s_d));
        chk({tag, ".wb"},   32'(wb_o), 32'(el && s_wb && (s_d != 5'd0)));
`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
        chk({tag, ".zero"}, 32'(zero), 32'(er == 32'h0));
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".res"},  res, 32'h0);
        chk({tag, ".ovf"},  32'(ovf), 32'h0);
        chk({tag, ".dest"}, 32'(dest_o), 32'h0);
        chk({tag, ".wb"},   32'(wb_o), 32'h0);
`ifdef JEDRO_1_ALU_ZERO_FLAG_EN
        chk({tag, ".zero"}, 32'(zero), 32'h0);
`endif
    endtask

    initial begin
        logic [3:0]  legal_ops [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
        logic [31:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1234};
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;

        // Reset held two cycles with nonzero inputs
        rst = 1'b1; op = 4'h0; a = 32'hDEADBEEF; b = 32'h11111111; dest_i = 5'd9; wb_i = 1'b1;
        @(posedge clk); #1; chk_reset("reset1");
        @(posedge clk); #1; chk_reset("reset2");
        rst = 1'b0;
        step("first", 4'h0, 32'd10, 32'd20, 5'd1, 1'b1);

        // Add/sub overflow corners
        step("add_ovf",   4'h0, 32'h7FFFFFFF, 32'h1,        5'd2, 1'b1);
        step("sub_ovf",   4'h8, 32'h80000000, 32'h1,        5'd2, 1'b1);
        step("add_neg",   4'h0, 32'd5,        32'hFFFFFFFD, 5'd2, 1'b1);
        step("add_wrap",  4'h0, 32'hFFFFFFFF, 32'h1,        5'd2, 1'b1);

        // Shifts use only the low five bits of B
        step("srl",       4'h5, 32'h80000000, 32'h24, 5'd4, 1'b1);
        step("sra",       4'hD, 32'h80000000, 32'h24, 5'd4, 1'b1);
        step("sll31",     4'h1, 32'h1,        32'd31, 5'd4, 1'b1);
        step("sll0",      4'h1, 32'hA5A5A5A5, 32'h20, 5'd4, 1'b1);

        // Compares and logic
        step("slt",       4'h2, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1);
        step("sltu",      4'h3, 32'hFFFFFFFF, 32'h1, 5'd5, 1'b1);
        step("slt0",      4'h2, 32'hFFFFFFFF, 32'h0, 5'd5, 1'b1);
        step("sltu0",     4'h3, 32'hFFFFFFFF, 32'h0, 5'd5, 1'b1);
        step("xor",       4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd6, 1'b1);
        step("or",        4'h6, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd6, 1'b1);
        step("and",       4'h7, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd6, 1'b1);

        // Back-to-back writeback gating
        step("wb_d3",     4'h0, 32'd1, 32'd2, 5'd3, 1'b1);
        step("wb_x0",     4'h0, 32'd3, 32'd4, 5'd0, 1'b1);
        step("wb_off",    4'h8, 32'd9, 32'd4, 5'd7, 1'b0);
        step("illegal",   4'hF, 32'h12345678, 32'h9, 5'd8, 1'b1);

        // Zero result then nonzero
        step("sub_zero",  4'h8, 32'h1234, 32'h1234, 5'd10, 1'b1);
        step("add_one",   4'h0, 32'd1,    32'd1,    5'd10, 1'b1);

        // Reset in the middle of a stream
        rst = 1'b1; op = 4'h0; a = 32'h7FFFFFFF; b = 32'h1; dest_i = 5'd12; wb_i = 1'b1;
        @(posedge clk); #1; chk_reset("mid_reset");
        rst = 1'b0;

        // Random ops, operands biased towards corner values
        for (int i = 0; i < 400; i++) begin
            r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 9)];
            r_a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1; op = r_op; a = r_a; b = r_b; dest_i = 5'($urandom); wb_i = 1'b1;
                @(posedge clk); #1; chk_reset("rnd_reset");
                rst = 1'b0;
            end else begin
                step("rnd", r_op, r_a, r_b, 5'($urandom), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
